// File: rtl/and_result_checker.sv
// Response checker for the two-input AND unit: recomputes po_c1/po_c2 from pi_a/pi_b and tallies mismatches.
// Optional build macro CHK_HALT_ON_ERR_EN ends a run on the first mismatch.
module and_result_checker #(
  parameter int NUM_SAMPLES = 1000,
  parameter int SETTLE_CYC  = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             chk_a,
  input  logic             chk_b,
  input  logic             chk_c1,
  input  logic             chk_c2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [1:0]       first_err_flags
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] NUM_LIM     = CNT_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SET_W-1:0] settle_cnt;
  logic             ab_d;
  logic             hist_vld;

  logic             exp_c1;
  logic [1:0]       mism;
  logic [CNT_W-1:0] sample_inc;
  logic             hit_limit;
  logic             first_err;

  // The registered output lags a/b by one cycle, so its reference is last cycle's a&b.
  always_comb begin
    exp_c1     = chk_a & chk_b;
    mism       = {hist_vld & (chk_c2 != ab_d), chk_c1 != exp_c1};
    sample_inc = sample_cnt + 1'b1;
    hit_limit  = (NUM_SAMPLES != 0) && (sample_inc == NUM_LIM);
    first_err  = (mism != 2'b00) && (err_cnt == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (stop)                  state_nxt = DONE;
        else if (settle_cnt == '0) state_nxt = RUN;
      end
      RUN: begin
        if (stop || hit_limit) state_nxt = DONE;
`ifdef CHK_HALT_ON_ERR_EN
        else if (first_err)    state_nxt = DONE;
`endif
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state == SETTLE) || (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ab_d     <= 1'b0;
      hist_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      ab_d  <= chk_a & chk_b;
      if (state == IDLE)        hist_vld <= 1'b0;
      else if (state == SETTLE) hist_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (state == IDLE && start) begin
      settle_cnt <= SETTLE_LOAD;
    end else if (state == SETTLE && settle_cnt != '0) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  // Results are cleared only by a new start so they stay readable in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt      <= '0;
      err_cnt         <= '0;
      first_err_idx   <= '0;
      first_err_flags <= 2'b00;
      pass            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sample_cnt      <= '0;
            err_cnt         <= '0;
            first_err_idx   <= '0;
            first_err_flags <= 2'b00;
            pass            <= 1'b0;
          end
        end
        RUN: begin
          sample_cnt <= sample_inc;
          if (mism != 2'b00 && err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
          if (first_err) begin
            first_err_idx   <= sample_cnt;
            first_err_flags <= mism;
          end
        end
        DONE: begin
          pass <= (err_cnt == '0);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and_result_checker.sv
// Scoreboard bench for and_result_checker: one instance with a 16-sample limit, one free-running.
// Expected run results are queued as stimulus is driven and compared when done pulses.
module tb_and_result_checker;

  localparam int CNT_W      = 16;
  localparam int SETTLE_CYC = 2;
  localparam int NUM_A      = 16;

  logic clk = 1'b0;
  logic rst, start, stop, chk_a, chk_b, chk_c1, chk_c2, sel;
  logic start_a, start_b, stop_a, stop_b;

  logic             busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [CNT_W-1:0] err_a, scnt_a, fidx_a, err_b, scnt_b, fidx_b;
  logic [1:0]       fflg_a, fflg_b;

  logic             busy_s, done_s, pass_s;
  logic [CNT_W-1:0] err_s, scnt_s, fidx_s;
  logic [1:0]       fflg_s;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign stop_a  = stop & ~sel;
  assign stop_b  = stop & sel;

  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;
  assign pass_s = sel ? pass_b : pass_a;
  assign err_s  = sel ? err_b  : err_a;
  assign scnt_s = sel ? scnt_b : scnt_a;
  assign fidx_s = sel ? fidx_b : fidx_a;
  assign fflg_s = sel ? fflg_b : fflg_a;

  and_result_checker #(.NUM_SAMPLES(NUM_A), .SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a),
    .chk_a(chk_a), .chk_b(chk_b), .chk_c1(chk_c1), .chk_c2(chk_c2),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .sample_cnt(scnt_a), .first_err_idx(fidx_a), .first_err_flags(fflg_a)
  );

  and_result_checker #(.NUM_SAMPLES(0), .SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b),
    .chk_a(chk_a), .chk_b(chk_b), .chk_c1(chk_c1), .chk_c2(chk_c2),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .sample_cnt(scnt_b), .first_err_idx(fidx_b), .first_err_flags(fflg_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         which;
    logic [15:0] scnt;
    logic [15:0] ecnt;
    logic [15:0] fidx;
    logic [1:0]  fflags;
    logic        pass;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;
  logic prev_ab = 1'b0;
  bit   pass_pending = 1'b0;
  logic pass_exp;
  int   pass_id;
  int   mon_id;
  exp_t mon_e;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic rbit();
    return ($urandom_range(0, 1) != 0);
  endfunction

  // Drives one cycle; the good AND unit's registered output is the previous cycle's a&b.
  task automatic applyStimulus(input logic a, input logic b, input logic c1_flip, input logic c2_unreg);
    chk_a  = a;
    chk_b  = b;
    chk_c1 = (a & b) ^ c1_flip;
    chk_c2 = c2_unreg ? (a & b) : prev_ab;
    @(posedge clk);
    prev_ab = rst ? 1'b0 : (a & b);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy_s), 32'd0);
    checkOutput({tag, "_done"}, 32'(done_s), 32'd0);
    checkOutput({tag, "_pass"}, 32'(pass_s), 32'd0);
    checkOutput({tag, "_err"},  32'(err_s),  32'd0);
    checkOutput({tag, "_scnt"}, 32'(scnt_s), 32'd0);
    checkOutput({tag, "_fidx"}, 32'(fidx_s), 32'd0);
    checkOutput({tag, "_fflg"}, 32'(fflg_s), 32'd0);
  endtask

  always @(negedge clk) begin
    if (pass_pending) begin
      checkOutput("pass", 32'(pass_id != 0 ? pass_b : pass_a), 32'(pass_exp));
      pass_pending = 1'b0;
    end
    if (done_a | done_b) begin
      mon_id = done_b ? 1 : 0;
      if (sb.size() == 0 || sb[0].which != mon_id) begin
        checkOutput("done_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("sample_cnt",      32'(mon_id != 0 ? scnt_b : scnt_a), 32'(mon_e.scnt));
        checkOutput("err_cnt",         32'(mon_id != 0 ? err_b  : err_a),  32'(mon_e.ecnt));
        checkOutput("first_err_idx",   32'(mon_id != 0 ? fidx_b : fidx_a), 32'(mon_e.fidx));
        checkOutput("first_err_flags", 32'(mon_id != 0 ? fflg_b : fflg_a), 32'(mon_e.fflags));
        pass_pending = 1'b1;
        pass_exp     = mon_e.pass;
        pass_id      = mon_id;
      end
    end
  end

  task automatic run_case(input int which, input int n_run, input bit use_stop, input int err_at,
                          input bit c2_unreg, input bit alt_a, input int start_mid, input int rst_at,
                          input bit start_stop);
    logic [15:0] m_cnt, m_err, m_idx;
    logic [1:0]  m_flags, m;
    logic        a, b, flip, c2drv;
    bit          term, first;
    exp_t        e;
    m_cnt = '0; m_err = '0; m_idx = '0; m_flags = '0;
    sel = which[0];
    if (start_stop) begin
      stop = 1'b1;
      applyStimulus(rbit(), rbit(), 1'b0, 1'b0);
      stop = 1'b0;
      checkOutput("stop_idle_busy", 32'(busy_s), 32'd0);
    end
    start = 1'b1;
    stop  = start_stop;
    applyStimulus(rbit(), rbit(), 1'b0, 1'b0);
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("busy_start", 32'(busy_s), 32'd1);
    for (int i = 0; i < SETTLE_CYC; i++) begin
      applyStimulus(rbit(), rbit(), 1'b0, 1'b0);
      checkOutput("busy_settle", 32'(busy_s), 32'd1);
    end
    for (int k = 0; k < n_run; k++) begin
      a = rbit(); b = rbit(); flip = 1'b0;
      if (alt_a) begin a = k[0]; b = 1'b1; end
      if (k == err_at) begin a = 1'b0; b = 1'b1; flip = 1'b1; end
      c2drv = c2_unreg ? (a & b) : prev_ab;
      if (k == rst_at) begin
        rst = 1'b1;
        applyStimulus(a, b, flip, c2_unreg);
        rst = 1'b0;
        checkAllZero("midrun_rst");
        return;
      end
      m = {c2drv != prev_ab, flip};
      first = (m != 2'b00) && (m_err == 16'd0);
      if (first) begin m_idx = m_cnt; m_flags = m; end
      if (m != 2'b00 && m_err != 16'hffff) m_err++;
      m_cnt++;
      term = (k == n_run - 1);
`ifdef CHK_HALT_ON_ERR_EN
      if (first) term = 1'b1;
`endif
      if (term) begin
        e.which = which; e.scnt = m_cnt; e.ecnt = m_err;
        e.fidx = m_idx; e.fflags = m_flags; e.pass = (m_err == 16'd0);
        sb.push_back(e);
      end
      start = (k == start_mid);
      stop  = use_stop && (k == n_run - 1);
      applyStimulus(a, b, flip, c2_unreg);
      start = 1'b0;
      stop  = 1'b0;
      if (term) begin
        checkOutput("busy_at_done", 32'(busy_s), 32'd0);
        checkOutput("done_pulse",   32'(done_s), 32'd1);
        break;
      end else begin
        checkOutput("busy_run", 32'(busy_s), 32'd1);
      end
    end
    applyStimulus(rbit(), rbit(), 1'b0, 1'b0);
    checkOutput("done_clear", 32'(done_s), 32'd0);
    checkOutput("busy_idle",  32'(busy_s), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; sel = 1'b0;
    chk_a = 1'b0; chk_b = 1'b0; chk_c1 = 1'b0; chk_c2 = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkAllZero("reset_a");
    sel = 1'b1;
    checkAllZero("reset_b");
    sel = 1'b0;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] clean run, stop-only idle cycle, start+stop together, start while busy");
    run_case(0, NUM_A, 1'b0, -1, 1'b0, 1'b0, 5, -1, 1'b1);
    $display("[TB] c1 fault on sample 3");
    run_case(0, NUM_A, 1'b0, 3, 1'b0, 1'b0, -1, -1, 1'b0);
    $display("[TB] c2 unregistered with alternating a");
    run_case(0, NUM_A, 1'b0, -1, 1'b1, 1'b1, -1, -1, 1'b0);
    $display("[TB] free-running instance stopped after 40 samples");
    run_case(1, 40, 1'b1, -1, 1'b0, 1'b0, -1, -1, 1'b0);
    $display("[TB] reset on 5th run cycle, then restart");
    run_case(0, NUM_A, 1'b0, -1, 1'b0, 1'b0, -1, 4, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    run_case(0, NUM_A, 1'b0, -1, 1'b0, 1'b0, -1, -1, 1'b0);
    $display("[TB] c1 fault on sample 7");
    run_case(0, NUM_A, 1'b0, 7, 1'b0, 1'b0, -1, -1, 1'b0);

    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
